// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit units: baud divisor
// derivation, parity encodings, FSM state codes and the latched frame config.
package uart_pkg;

  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd6;

  typedef struct packed {
    logic       stop2;
    logic       len8;
    logic [1:0] par;
    logic [1:0] baud;
  } rx_cfg_t;

  function automatic int baud_hz(input logic [1:0] sel);
    case (sel)
      2'd0:    return 2400;
      2'd1:    return 4800;
      2'd2:    return 9600;
      default: return 19200;
    endcase
  endfunction

  // Divisor rounded to nearest: 1302/651/326/163 at 50 MHz with 16x oversampling.
  function automatic int baud_div(input int clk_hz, input int os, input logic [1:0] sel);
    int step;
    step = os * baud_hz(sel);
    return (clk_hz + step / 2) / step;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: selects the divisor for baud_rate and emits a
// one-cycle tick every divisor clocks; restart realigns the count to zero.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       restart,
  input  logic [1:0] baud_rate,
  output logic       tick
);

  localparam logic [15:0] DIV0 = 16'(baud_div(CLK_HZ, OVERSAMPLE, 2'd0));
  localparam logic [15:0] DIV1 = 16'(baud_div(CLK_HZ, OVERSAMPLE, 2'd1));
  localparam logic [15:0] DIV2 = 16'(baud_div(CLK_HZ, OVERSAMPLE, 2'd2));
  localparam logic [15:0] DIV3 = 16'(baud_div(CLK_HZ, OVERSAMPLE, 2'd3));

  logic [15:0] div;
  logic [15:0] cnt;

  always_comb begin
    case (baud_rate)
      2'd0:    div = DIV0;
      2'd1:    div = DIV1;
      2'd2:    div = DIV2;
      default: div = DIV3;
    endcase
  end

  assign tick = (cnt == div - 16'd1);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/rx_unit.sv
// UART receive unit: 16x oversampled frame recovery with parity/framing status.
// Optional build macro RX_MAJORITY_VOTE_EN: 2-of-3 vote over ticks 7, 8 and 9.
module rx_unit
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       data_in,
  input  logic       stop_bits,
  input  logic       data_length,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic [7:0] data_out,
  output logic       rx_active,
  output logic       rx_done,
  output logic       parity_error,
  output logic       frame_error
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] SAMPLE_PH = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0] COMMIT_PH = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0] LAST_PH   = PH_W'(OVERSAMPLE - 1);

  logic            line_p0, line_p1, line_p2;
  logic [2:0]      state;
  rx_cfg_t         cfg;
  logic [PH_W-1:0] phase;
  logic [2:0]      bit_cnt;
  logic            stop_second;
  logic            ferr;
  logic            tick, start_edge, commit, bit_val, par_en, par_exp;
  logic [7:0]      shreg, word;
  logic            s_mid, par_bit;

  // Stage p0/p1: synchronizer; p2: previous value for falling-edge detect
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      line_p0 <= 1'b1;
      line_p1 <= 1'b1;
      line_p2 <= 1'b1;
    end else begin
      line_p0 <= data_in;
      line_p1 <= line_p0;
      line_p2 <= line_p1;
    end
  end

  assign start_edge = (state == ST_IDLE) && line_p2 && !line_p1;
  // Every bit decision is taken on the tick after the mid-bit sample, so both
  // builds share identical latency.
  assign commit     = tick && (phase == COMMIT_PH);
  assign par_en     = (cfg.par == PAR_ODD) || (cfg.par == PAR_EVEN);
  assign word       = cfg.len8 ? shreg : {1'b0, shreg[7:1]};
  assign par_exp    = (cfg.par == PAR_ODD) ? ~^word : ^word;
  assign rx_active  = (state == ST_START) || (state == ST_DATA) ||
                      (state == ST_PARITY) || (state == ST_STOP);

  baud_tick_gen #(
    .CLK_HZ    (CLK_HZ),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clock    (clock),
    .rst      (rst),
    .restart  (start_edge),
    .baud_rate(cfg.baud),
    .tick     (tick)
  );

`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [PH_W-1:0] EARLY_PH = PH_W'(OVERSAMPLE / 2 - 2);
  logic s_early;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clock) begin
    if (tick && phase == EARLY_PH) s_early <= line_p1;
  end

  assign bit_val = maj3(s_early, s_mid, line_p1);
`else
  assign bit_val = s_mid;
`endif

  // Sample/data stage: mid-bit sample, shift register and parity bit
  always_ff @(posedge clock) begin
    if (tick && phase == SAMPLE_PH) s_mid <= line_p1;
    if (commit && state == ST_DATA) shreg <= {bit_val, shreg[7:1]};
    if (commit && state == ST_PARITY) par_bit <= bit_val;
  end

  // Control stage: frame FSM and registered status outputs
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cfg          <= '0;
      phase        <= '0;
      bit_cnt      <= '0;
      stop_second  <= 1'b0;
      ferr         <= 1'b0;
      data_out     <= 8'h00;
      rx_done      <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (state != ST_IDLE && tick) phase <= (phase == LAST_PH) ? '0 : phase + 1'b1;
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            cfg   <= {stop_bits, data_length, parity_type, baud_rate};
            phase <= '0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (commit) begin
            state       <= bit_val ? ST_IDLE : ST_DATA;
            bit_cnt     <= '0;
            stop_second <= 1'b0;
            ferr        <= 1'b0;
          end
        end
        ST_DATA: begin
          if (commit) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == (cfg.len8 ? 3'd7 : 3'd6)) state <= par_en ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (commit) state <= ST_STOP;
        end
        ST_STOP: begin
          if (commit) begin
            if (cfg.stop2 && !stop_second) begin
              stop_second <= 1'b1;
              ferr        <= !bit_val;
            end else begin
              state        <= ST_DONE;
              rx_done      <= 1'b1;
              data_out     <= word;
              parity_error <= par_en && (par_bit != par_exp);
              frame_error  <= ferr || !bit_val;
            end
          end
        end
        // A line still low here is a break; wait for idle so it cannot start a frame.
        ST_DONE:      state <= line_p1 ? ST_IDLE : ST_WAIT_HIGH;
        ST_WAIT_HIGH: if (line_p1) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_unit.sv
// Directed bench for rx_unit; CLK_HZ is scaled so divisors are 64/32/16/8.
module tb_rx_unit;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       data_in = 1'b1;
  logic       stop_bits = 1'b0;
  logic       data_length = 1'b1;
  logic [1:0] parity_type = 2'b00;
  logic [1:0] baud_rate = 2'b00;
  logic [7:0] data_out;
  logic       rx_active, rx_done, parity_error, frame_error;

  int   checks = 0;
  int   errors = 0;
  int   done_cyc = 0;
  logic act_prev = 1'b0;

  rx_unit #(
    .CLK_HZ    (2_457_600),
    .OVERSAMPLE(16)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .data_in     (data_in),
    .stop_bits   (stop_bits),
    .data_length (data_length),
    .parity_type (parity_type),
    .baud_rate   (baud_rate),
    .data_out    (data_out),
    .rx_active   (rx_active),
    .rx_done     (rx_done),
    .parity_error(parity_error),
    .frame_error (frame_error)
  );

  always #5 clock = ~clock;

  // rx_done must coincide with rx_active falling from 1 to 0
  always @(negedge clock) begin
    if (rx_done) begin
      done_cyc++;
      checks++;
      assert (act_prev === 1'b1 && rx_active === 1'b0)
      else begin
        errors++;
        $error("FAIL active_edge observed prev=%0b now=%0b expected prev=1 now=0", act_prev, rx_active);
      end
    end
    act_prev <= rx_active;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives n line bits LSB first, each bclk clocks long; leaves the last value.
  task automatic send(input logic [15:0] bits, input int n, input int bclk);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      data_in = bits[i];
      repeat (bclk - 1) @(negedge clock);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #1;
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_rx_active", 32'(rx_active), 32'h0);
    check("rst_rx_done", 32'(rx_done), 32'h0);
    check("rst_parity_error", 32'(parity_error), 32'h0);
    check("rst_frame_error", 32'(frame_error), 32'h0);
    idle(5);
    rst = 1'b1;
    idle(20);

    // 8N1 at 2400 (bit = 1024 clocks), 0xAA
    send(16'b1_10101010_0, 10, 1024);
    idle(2);
    check("f1_done_count", 32'(done_cyc), 32'd1);
    check("f1_data", 32'(data_out), 32'hAA);
    check("f1_perr", 32'(parity_error), 32'h0);
    check("f1_ferr", 32'(frame_error), 32'h0);
    check("f1_active_idle", 32'(rx_active), 32'h0);

    // 8O1 at 4800 (bit = 512 clocks), 0x55 with correct odd parity bit 1
    parity_type = 2'b01;
    baud_rate   = 2'b01;
    send(16'b1_1_01010101_0, 11, 512);
    idle(2);
    check("f2_done_count", 32'(done_cyc), 32'd2);
    check("f2_data", 32'(data_out), 32'h55);
    check("f2_perr", 32'(parity_error), 32'h0);

    // Same frame with the parity bit flipped
    send(16'b1_0_01010101_0, 11, 512);
    idle(2);
    check("f3_done_count", 32'(done_cyc), 32'd3);
    check("f3_data", 32'(data_out), 32'h55);
    check("f3_perr", 32'(parity_error), 32'h1);
    check("f3_ferr", 32'(frame_error), 32'h0);

    // 7E2 at 9600 (bit = 256 clocks), 0x2A, even parity 1; config scrambled mid-frame
    stop_bits   = 1'b1;
    data_length = 1'b0;
    parity_type = 2'b10;
    baud_rate   = 2'b10;
    fork
      send(16'b1_1_1_0101010_0, 11, 256);
      begin
        idle(600);
        stop_bits   = 1'b0;
        data_length = 1'b1;
        parity_type = 2'b00;
        baud_rate   = 2'b11;
      end
    join
    idle(2);
    check("f4_done_count", 32'(done_cyc), 32'd4);
    check("f4_data", 32'(data_out), 32'h2A);
    check("f4_perr", 32'(parity_error), 32'h0);
    check("f4_ferr", 32'(frame_error), 32'h0);

    // 7E2 with the second stop bit low
    stop_bits   = 1'b1;
    data_length = 1'b0;
    parity_type = 2'b10;
    baud_rate   = 2'b10;
    send(16'b0_1_1_0101010_0, 11, 256);
    data_in = 1'b1;
    idle(300);
    check("f5_done_count", 32'(done_cyc), 32'd5);
    check("f5_data", 32'(data_out), 32'h2A);
    check("f5_ferr", 32'(frame_error), 32'h1);
    check("f5_perr", 32'(parity_error), 32'h0);

    // 8N1 at 19200 (bit = 128 clocks): 5-clock glitch on idle line
    stop_bits   = 1'b0;
    data_length = 1'b1;
    parity_type = 2'b00;
    baud_rate   = 2'b11;
    idle(10);
    data_in = 1'b0;
    idle(5);
    data_in = 1'b1;
    idle(5);
    check("glitch_detected", 32'(rx_active), 32'h1);
    idle(118);
    check("glitch_rejected", 32'(rx_active), 32'h0);
    check("glitch_no_done", 32'(done_cyc), 32'd5);

    // 8N1 at 4800: reset during DATA of 0xF0, then a clean 0x0F
    baud_rate = 2'b01;
    send(16'b1_11110000_0, 5, 512);
    idle(100);
    rst = 1'b0;
    #1;
    check("mid_rst_data_out", 32'(data_out), 32'h00);
    check("mid_rst_active", 32'(rx_active), 32'h0);
    check("mid_rst_ferr", 32'(frame_error), 32'h0);
    check("mid_rst_done", 32'(rx_done), 32'h0);
    data_in = 1'b1;
    idle(5);
    rst = 1'b1;
    idle(512);
    check("post_rst_no_done", 32'(done_cyc), 32'd5);
    send(16'b1_00001111_0, 10, 512);
    idle(2);
    check("f6_done_count", 32'(done_cyc), 32'd6);
    check("f6_data", 32'(data_out), 32'h0F);
    check("f6_ferr", 32'(frame_error), 32'h0);

    // 8N1 at 19200: line held low for 20 bit times
    baud_rate = 2'b11;
    data_in = 1'b0;
    idle(20 * 128);
    check("brk_done_count", 32'(done_cyc), 32'd7);
    check("brk_data", 32'(data_out), 32'h00);
    check("brk_ferr", 32'(frame_error), 32'h1);
    check("brk_active_low", 32'(rx_active), 32'h0);
    data_in = 1'b1;
    idle(3 * 128);
    check("brk_no_extra_done", 32'(done_cyc), 32'd7);
    check("brk_idle", 32'(rx_active), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
